// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM state encoding and the command record.
package apb_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic              write;
    logic [APB_AW-1:0] addr;
    logic [APB_DW-1:0] wdata;
  } apb_cmd_t;

  // Smallest counter width able to hold TIMEOUT_CYCLES-1.
  function automatic int timeout_ctr_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/apb_timeout_ctr.sv
// Counts stalled ACCESS cycles and flags expiry at TIMEOUT_CYCLES-1 (used under APB_TIMEOUT_EN).
module apb_timeout_ctr
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = timeout_ctr_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Saturates at LAST so the flag stays up until the requester leaves ACCESS.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: valid/ready command in, SETUP/ACCESS transfers out, one response pulse per command.
// Optional ACCESS timeout abort enabled by defining APB_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0]    cmd_wdata,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     M_PSEL,
  output logic                     M_PENABLE,
  output logic                     M_PWRITE,
  output logic [ADDRESS_WIDTH-1:0] M_PADDR,
  output logic [DATA_WIDTH-1:0]    M_PWDATA,
  input  logic                     M_PREADY,
  input  logic [DATA_WIDTH-1:0]    M_PRDATA
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be at least 2");
  end

  apb_state_e state;
  logic       timeout_abort;

`ifdef APB_TIMEOUT_EN
  logic timeout_expired;

  apb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk    (PCLK),
    .reset  (PRESET),
    .clear  (state != APB_ACCESS),
    .enable ((state == APB_ACCESS) && !M_PREADY),
    .expired(timeout_expired)
  );

  // PREADY in the expiry cycle wins, so only a still-stalled slave aborts.
  assign timeout_abort = (state == APB_ACCESS) && !M_PREADY && timeout_expired;
`else
  assign timeout_abort = 1'b0;
`endif

  // A completing ACCESS cycle can take the next command directly (back-to-back).
  always_comb begin
    cmd_ready = 1'b0;
    case (state)
      APB_IDLE:   cmd_ready = 1'b1;
      APB_ACCESS: cmd_ready = M_PREADY;
      default:    cmd_ready = 1'b0;
    endcase
  end

  assign busy = (state != APB_IDLE);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= APB_IDLE;
      M_PSEL    <= 1'b0;
      M_PENABLE <= 1'b0;
      M_PWRITE  <= 1'b0;
      M_PADDR   <= '0;
      M_PWDATA  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (state)
        APB_IDLE: begin
          if (cmd_valid) begin
            M_PWRITE  <= cmd_write;
            M_PADDR   <= cmd_addr;
            M_PWDATA  <= cmd_wdata;
            M_PSEL    <= 1'b1;
            M_PENABLE <= 1'b0;
            state     <= APB_SETUP;
          end
        end
        APB_SETUP: begin
          M_PENABLE <= 1'b1;
          state     <= APB_ACCESS;
        end
        APB_ACCESS: begin
          if (M_PREADY) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= M_PWRITE ? '0 : M_PRDATA;
            M_PENABLE <= 1'b0;
            if (cmd_valid) begin
              M_PWRITE <= cmd_write;
              M_PADDR  <= cmd_addr;
              M_PWDATA <= cmd_wdata;
              state    <= APB_SETUP;
            end else begin
              M_PSEL <= 1'b0;
              state  <= APB_IDLE;
            end
          end else if (timeout_abort) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            M_PSEL    <= 1'b0;
            M_PENABLE <= 1'b0;
            state     <= APB_IDLE;
          end
        end
        default: begin
          M_PSEL    <= 1'b0;
          M_PENABLE <= 1'b0;
          state     <= APB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: table of single transfers, hand-written corner sequences,
// and a randomized phase scored against an in-order transaction model.
`timescale 1ns/1ps
module tb_apb_master;
  import apb_pkg::*;

  localparam int AW = APB_AW;
  localparam int DW = APB_DW;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          busy;
  logic          M_PSEL;
  logic          M_PENABLE;
  logic          M_PWRITE;
  logic [AW-1:0] M_PADDR;
  logic [DW-1:0] M_PWDATA;
  logic          M_PREADY = 1'b0;
  logic [DW-1:0] M_PRDATA = '0;

  always #5 PCLK = ~PCLK;

  apb_master #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .M_PSEL   (M_PSEL),
    .M_PENABLE(M_PENABLE),
    .M_PWRITE (M_PWRITE),
    .M_PADDR  (M_PADDR),
    .M_PWDATA (M_PWDATA),
    .M_PREADY (M_PREADY),
    .M_PRDATA (M_PRDATA)
  );

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual === required) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
  endtask

  task automatic applyStimulus(input apb_cmd_t c, input logic valid);
    cmd_valid = valid;
    cmd_write = c.write;
    cmd_addr  = c.addr;
    cmd_wdata = c.wdata;
  endtask

  // Slave model: memory with a programmable number of wait states per ACCESS.
  logic [DW-1:0] slave_mem [logic [AW-1:0]];
  int            wait_target = 0;
  int            acc_cnt = 0;
  bit            rand_waits = 1'b0;

  always @(negedge PCLK) begin
    if (M_PSEL && M_PENABLE) begin
      if (acc_cnt == 0 && rand_waits) wait_target = $urandom_range(0, 3);
      if (acc_cnt >= wait_target) begin
        M_PREADY = 1'b1;
        if (M_PWRITE) begin
          slave_mem[M_PADDR] = M_PWDATA;
          M_PRDATA = $urandom;
        end else begin
          M_PRDATA = slave_mem.exists(M_PADDR) ? slave_mem[M_PADDR] : '0;
        end
      end else begin
        M_PREADY = 1'b0;
        M_PRDATA = $urandom;
      end
      acc_cnt++;
    end else begin
      M_PREADY = 1'($urandom_range(0, 1));
      M_PRDATA = $urandom;
      acc_cnt  = 0;
    end
  end

  // Reference model: responses come back in command order; reads see all earlier writes.
  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  rsp_t          exp_q[$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int            rsp_count = 0;

  task automatic modelAccept(input apb_cmd_t c);
    rsp_t e;
    if (c.write) begin
      ref_mem[c.addr] = c.wdata;
      e.rdata = '0;
    end else begin
      e.rdata = ref_mem.exists(c.addr) ? ref_mem[c.addr] : '0;
    end
    e.err = 1'b0;
    exp_q.push_back(e);
  endtask

  always @(negedge PCLK) begin
    rsp_t e;
    if (rsp_valid) begin
      rsp_count++;
      checkOutput("rsp_pending", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("rsp_rdata", rsp_rdata, e.rdata);
        checkOutput("rsp_err", rsp_err, e.err);
      end
    end
  end

  typedef struct {
    apb_cmd_t      cmd;
    int            waits;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic runTransfer(input vec_t v);
    int good = 0;
    rsp_t e;
    @(negedge PCLK);
    wait_target = v.waits;
    applyStimulus(v.cmd, 1'b1);
    #2;
    checkOutput("idle_cmd_ready", cmd_ready, 1);
    e.rdata = v.exp_rdata;
    e.err   = 1'b0;
    exp_q.push_back(e);
    @(negedge PCLK);
    applyStimulus(v.cmd, 1'b0);
    checkOutput("setup_phase", {M_PSEL, M_PENABLE, cmd_ready, busy}, 4'b1001);
    for (int k = 0; k <= v.waits; k++) begin
      @(negedge PCLK);
      if (M_PSEL && M_PENABLE && !rsp_valid && busy && M_PADDR == v.cmd.addr &&
          M_PWRITE == v.cmd.write && (!v.cmd.write || M_PWDATA == v.cmd.wdata)) good++;
    end
    checkOutput("access_hold", good, v.waits + 1);
    @(negedge PCLK);
    checkOutput("rsp_latency", {rsp_valid, M_PSEL, M_PENABLE, busy}, 4'b1000);
    @(negedge PCLK);
    checkOutput("rsp_single", rsp_valid, 0);
  endtask

  task automatic backToBack();
    apb_cmd_t   cmds[3];
    logic [6:0] psel_seen;
    logic [6:0] rsp_seen;
    int         idx;
    cmds[0] = '{1'b1, 32'h0, 32'h1111_0000};
    cmds[1] = '{1'b1, 32'h4, 32'h2222_0004};
    cmds[2] = '{1'b1, 32'h8, 32'h3333_0008};
    rand_waits  = 1'b0;
    wait_target = 0;
    @(negedge PCLK);
    applyStimulus(cmds[0], 1'b1);
    #2;
    modelAccept(cmds[0]);
    idx = 1;
    @(posedge PCLK); #1;
    applyStimulus(cmds[1], 1'b1);
    for (int c = 0; c < 7; c++) begin
      @(negedge PCLK); #2;
      psel_seen[c] = M_PSEL;
      rsp_seen[c]  = rsp_valid;
      if (cmd_valid && cmd_ready && idx < 3) begin
        modelAccept(cmds[idx]);
        idx++;
      end
      @(posedge PCLK); #1;
      if (idx < 3) applyStimulus(cmds[idx], 1'b1);
      else applyStimulus(cmds[0], 1'b0);
    end
    checkOutput("b2b_accepts", idx, 3);
    checkOutput("b2b_psel", psel_seen, 7'b0111111);
    checkOutput("b2b_rsp", rsp_seen, 7'b1010100);
  endtask

  task automatic resetMidAccess();
    apb_cmd_t c;
    int       base;
    c = '{1'b1, 32'h40, 32'h0BAD_F00D};
    wait_target = 10;
    @(negedge PCLK);
    applyStimulus(c, 1'b1);
    @(negedge PCLK);
    applyStimulus(c, 1'b0);
    @(negedge PCLK);
    @(negedge PCLK);
    checkOutput("pre_reset_access", {M_PSEL, M_PENABLE}, 2'b11);
    base = rsp_count;
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    checkOutput("reset_mid_access", {M_PSEL, M_PENABLE, rsp_valid, cmd_ready, busy}, 5'b00010);
    repeat (3) @(negedge PCLK);
    #2;
    checkOutput("reset_no_rsp", rsp_count - base, 0);
    wait_target = 0;
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic timeoutAbort();
    apb_cmd_t c;
    rsp_t     e;
    int       n = 0;
    int       guard = 0;
    c = '{1'b0, 32'h44, 32'h0};
    wait_target = 1000;
    @(negedge PCLK);
    applyStimulus(c, 1'b1);
    e.rdata = '0;
    e.err   = 1'b1;
    exp_q.push_back(e);
    @(negedge PCLK);
    applyStimulus(c, 1'b0);
    @(negedge PCLK);
    while (!rsp_valid && guard < 40) begin
      if (M_PENABLE) n++;
      guard++;
      @(negedge PCLK);
    end
    checkOutput("timeout_access_cycles", n, 16);
    checkOutput("timeout_idle", {rsp_valid, busy, M_PSEL}, 3'b100);
    wait_target = 0;
  endtask
`endif

  task automatic randomPhase(input int n);
    apb_cmd_t c;
    int       accepted = 0;
    int       base;
    int       guard = 0;
    base = rsp_count;
    rand_waits = 1'b1;
    @(posedge PCLK); #1;
    for (int i = 0; i < n; i++) begin
      c.write = 1'($urandom_range(0, 1));
      c.addr  = 32'h100 + 32'(4 * $urandom_range(0, 7));
      c.wdata = $urandom;
      applyStimulus(c, $urandom_range(0, 9) < 7);
      @(negedge PCLK); #2;
      if (cmd_valid && cmd_ready) begin
        modelAccept(c);
        accepted++;
      end
      @(posedge PCLK); #1;
    end
    applyStimulus(c, 1'b0);
    while (exp_q.size() > 0 && guard < 100) begin
      @(negedge PCLK); #2;
      guard++;
    end
    checkOutput("random_drain", exp_q.size(), 0);
    checkOutput("random_rsp_count", rsp_count - base, accepted);
    @(negedge PCLK);
    checkOutput("random_idle", busy, 0);
    rand_waits  = 1'b0;
    wait_target = 0;
  endtask

  initial begin
    apb_cmd_t zero;
    zero = '0;
    PRESET = 1'b1;
    applyStimulus(zero, 1'b0);
    repeat (2) @(negedge PCLK);
    checkOutput("reset_ctrl", {cmd_ready, M_PSEL, M_PENABLE, M_PWRITE, rsp_valid, rsp_err, busy}, 7'b1000000);
    checkOutput("reset_paddr", M_PADDR, 0);
    checkOutput("reset_pwdata", M_PWDATA, 0);
    checkOutput("reset_rdata", rsp_rdata, 0);
    PRESET = 1'b0;

    vecs[0] = '{cmd: '{1'b1, 32'h10, 32'hDEAD_BEEF}, waits: 1, exp_rdata: 32'h0};
    vecs[1] = '{cmd: '{1'b0, 32'h10, 32'h0},         waits: 1, exp_rdata: 32'hDEAD_BEEF};
    vecs[2] = '{cmd: '{1'b1, 32'h20, 32'hCAFE_F00D}, waits: 0, exp_rdata: 32'h0};
    vecs[3] = '{cmd: '{1'b0, 32'h20, 32'h0},         waits: 2, exp_rdata: 32'hCAFE_F00D};
    vecs[4] = '{cmd: '{1'b0, 32'h30, 32'h0},         waits: 0, exp_rdata: 32'h0};
    vecs[5] = '{cmd: '{1'b1, 32'h10, 32'h1234_5678}, waits: 5, exp_rdata: 32'h0};
    vecs[6] = '{cmd: '{1'b0, 32'h10, 32'h0},         waits: 0, exp_rdata: 32'h1234_5678};
    vecs[7] = '{cmd: '{1'b0, 32'h20, 32'h0},         waits: 5, exp_rdata: 32'hCAFE_F00D};

    for (int i = 0; i < 8; i++) runTransfer(vecs[i]);

    backToBack();
    runTransfer('{cmd: '{1'b0, 32'h4, 32'h0}, waits: 1, exp_rdata: 32'h2222_0004});
    resetMidAccess();
`ifdef APB_TIMEOUT_EN
    timeoutAbort();
`endif
    randomPhase(200);

    repeat (2) @(negedge PCLK);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not reach the end, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
